// File: rtl/rc4_host_if.sv
// rc4_host_if: byte-stream handshake between the session host and an RC4 engine.
interface rc4_host_if;
    logic       key_valid;
    logic [7:0] key_in;
    logic       plain_read;
    logic       plain_in_valid;
    logic [7:0] plain_in;
    logic       cipher_write;
    logic [7:0] cipher_out;
    logic       cipher_read;
    logic       cipher_in_valid;
    logic [7:0] cipher_in;
    logic       plain_write;
    logic [7:0] plain_out;
    logic       done;
    modport master (
        output key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid, cipher_in,
        input  plain_read, cipher_write, cipher_out, cipher_read, plain_write, plain_out, done
    );
    modport slave (
        input  key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid, cipher_in,
        output plain_read, cipher_write, cipher_out, cipher_read, plain_write, plain_out, done
    );
endinterface

// File: rtl/rc4_host.sv
// rc4_host: feeds key and message to an RC4 engine, buffers the ciphertext, replays it and checks the recovered text.
// Optional watchdog with output timeout is enabled by defining RC4_HOST_TIMEOUT_EN.
module rc4_host #(
    parameter int KEY_LEN = 32,
    parameter int MSG_LEN = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       fin,
    output logic       pass,
    output logic [7:0] err_count,
    rc4_host_if.master e
`ifdef RC4_HOST_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);
    typedef enum logic [2:0] {IDLE, KEY, ENC, DEC, WAIT_DONE, FIN} state_t;
    state_t     state;
    logic [7:0] key_mem [256];
    logic [7:0] msg_mem [256];
    logic [7:0] cbuf [256];
    logic [5:0] c;
    logic [8:0] pidx, cidx, ridx, oidx;
    logic       ppend, cpend, cap_c, cap_p;

    if (KEY_LEN < 1 || KEY_LEN > 32 || MSG_LEN < 1 || MSG_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
        $error("rc4_host: parameter out of range");
    end

    assign e.plain_in_valid  = state == ENC && e.plain_read && pidx < 9'(MSG_LEN);
    assign e.plain_in        = msg_mem[pidx[7:0]];
    assign e.cipher_in_valid = state == DEC && e.cipher_read && ridx < 9'(MSG_LEN);
    assign e.cipher_in       = cbuf[ridx[7:0]];
    // A strobe only counts in the cycle right after a byte was handed out.
    assign cap_c   = state == ENC && e.cipher_write && ppend;
    assign cap_p   = state == DEC && e.plain_write && cpend;
    assign rd_data = cbuf[rd_addr];
    assign busy    = state inside {KEY, ENC, DEC, WAIT_DONE};

    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we && !cfg_sel) key_mem[cfg_addr] <= cfg_data;
        if (state == IDLE && cfg_we && cfg_sel) msg_mem[cfg_addr] <= cfg_data;
        if (cap_c) cbuf[cidx[7:0]] <= e.cipher_out;
    end

`ifdef RC4_HOST_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            c           <= '0;
            pidx        <= '0;
            cidx        <= '0;
            ridx        <= '0;
            oidx        <= '0;
            ppend       <= 1'b0;
            cpend       <= 1'b0;
            e.key_valid <= 1'b0;
            e.key_in    <= '0;
            fin         <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
`ifdef RC4_HOST_TIMEOUT_EN
            wd          <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            ppend <= e.plain_in_valid;
            cpend <= e.cipher_in_valid;
            if (e.plain_in_valid) pidx <= pidx + 9'd1;
            if (e.cipher_in_valid) ridx <= ridx + 9'd1;
            if (cap_c) cidx <= cidx + 9'd1;
            if (cap_p) begin
                oidx <= oidx + 9'd1;
                if (e.plain_out != msg_mem[oidx[7:0]] && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            case (state)
                IDLE: if (start) begin
                    state       <= KEY;
                    e.key_valid <= 1'b1;
                    e.key_in    <= key_mem[0];
                    c           <= '0;
                end
                // The engine sees key[0] twice: once as a lead-in byte, then the full key.
                KEY: if (c == 6'(KEY_LEN)) begin
                    e.key_valid <= 1'b0;
                    state       <= ENC;
                end else begin
                    c        <= c + 6'd1;
                    e.key_in <= key_mem[8'(c)];
                end
                ENC: if (cidx == 9'(MSG_LEN)) state <= DEC;
                DEC: if (oidx == 9'(MSG_LEN)) state <= WAIT_DONE;
                WAIT_DONE: if (e.done) begin
                    state <= FIN;
                    fin   <= 1'b1;
                    pass  <= err_count == 8'd0;
                end
                default: ;
            endcase
`ifdef RC4_HOST_TIMEOUT_EN
            if (!(state inside {ENC, DEC, WAIT_DONE}) || cap_c || cap_p || e.done) wd <= '0;
            else if (wd == WDW'(TIMEOUT - 1)) begin
                state   <= FIN;
                fin     <= 1'b1;
                pass    <= 1'b0;
                timeout <= 1'b1;
            end else wd <= wd + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_rc4_host.sv
// tb_rc4_host: randomized RC4 sessions driven by a behavioural engine, checked against an RC4 reference model.
module tb_rc4_host;
    localparam int KL = 32;
    localparam int ML = 16;
    typedef logic [7:0] bq_t[$];
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, cfg_we = 1'b0, cfg_sel = 1'b0;
    logic [7:0] cfg_addr = '0, cfg_data = '0, rd_addr = '0;
    logic [7:0] rd_data, err_count;
    logic       busy, fin, pass;
`ifdef RC4_HOST_TIMEOUT_EN
    logic       timeout;
`endif
    logic [7:0] key_m [256];
    logic [7:0] msg_m [256];
    bq_t        ct_m;
    int         n_cmp = 0, n_bad = 0, kcnt = 0, pcnt = 0, ccnt = 0;
    bit         mon = 1'b0;

    rc4_host_if e ();
    rc4_host #(.KEY_LEN(KL), .MSG_LEN(ML), .TIMEOUT(4096)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .fin(fin), .pass(pass), .err_count(err_count), .e(e)
`ifdef RC4_HOST_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t rc4(bq_t k, int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        bq_t o;
        for (int x = 0; x < 256; x++) s[x] = x[7:0];
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + s[x] + k[x % k.size()];
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int x = 0; x < n; x++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            o.push_back(s[t]);
        end
        return o;
    endfunction

    function automatic bq_t model_ct();
        bq_t k, ks, o;
        for (int i = 0; i < KL; i++) k.push_back(key_m[i]);
        ks = rc4(k, ML);
        for (int i = 0; i < ML; i++) o.push_back(msg_m[i] ^ ks[i]);
        return o;
    endfunction

    // Compare process: every byte the host hands out must follow the model's stream order.
    always @(negedge clk) if (mon) begin
        if (e.key_valid) begin
            chk("key_in", 32'({kcnt <= KL, e.key_in}), 32'({1'b1, kcnt == 0 ? key_m[0] : key_m[8'(kcnt - 1)]}));
            kcnt++;
        end
        if (e.plain_in_valid) begin
            chk("plain_in", 32'({pcnt < ML, e.plain_in}), 32'({1'b1, msg_m[8'(pcnt)]}));
            pcnt++;
        end
        if (e.cipher_in_valid) begin
            chk("cipher_in", 32'({ccnt < ML, e.cipher_in}), 32'({1'b1, ccnt < ML ? ct_m[ccnt] : 8'h00}));
            ccnt++;
        end
    end

    task automatic load(input logic sel, input logic [7:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
        if (sel) msg_m[a] = d; else key_m[a] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fin", 32'(fin), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_key_valid", 32'(e.key_valid), 0);
        chk("rst_key_in", 32'(e.key_in), 0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic engine(input int flip, input int extra, output bq_t kb);
        bq_t k2, ks;
        logic [7:0] pb = '0, cb = '0;
        bit pp = 1'b0, cp = 1'b0;
        int na = 0, nc = 0, nr = 0, no = 0, g = 0;
        kb.delete();
        while (e.key_valid && g < 100) begin
            kb.push_back(e.key_in);
            e.plain_read = 1'($urandom);
            e.cipher_read = 1'($urandom);
            tick();
            cfg_we = 1'b0;
            g++;
        end
        cfg_we = 1'b0;
        k2 = kb;
        if (k2.size() > 0) void'(k2.pop_front());
        if (k2.size() == 0) k2.push_back(8'h00);
        ks = rc4(k2, ML);
        g = 0;
        while (nc < ML && g < 2000) begin
            e.cipher_write = pp || (extra != 0 && 1'($urandom));
            e.cipher_out = pp ? pb ^ ks[nc] : 8'($urandom);
            if (pp) nc++;
            e.plain_read = na < ML && $urandom_range(0, 3) != 0;
            e.cipher_read = 1'($urandom);
            #1;
            pp = e.plain_in_valid;
            pb = e.plain_in;
            if (pp) na++;
            tick();
            g++;
        end
        e.plain_read = 1'b0;
        repeat (extra) begin
            e.cipher_write = 1'b1;
            e.cipher_out = 8'($urandom);
            tick();
        end
        e.cipher_write = 1'b0;
        g = 0;
        while (no < ML && g < 2000) begin
            e.plain_write = cp || (extra != 0 && 1'($urandom));
            e.plain_out = cp ? cb ^ ks[no] ^ 8'(no == flip) : 8'($urandom);
            if (cp) no++;
            e.cipher_read = nr < ML && $urandom_range(0, 3) != 0;
            #1;
            cp = e.cipher_in_valid;
            cb = e.cipher_in;
            if (cp) nr++;
            tick();
            g++;
        end
        e.plain_write = 1'b0;
        e.cipher_read = 1'b0;
        repeat (1 + $urandom_range(0, 3)) tick();
        e.done = 1'b1;
        g = 0;
        while (!fin && g < 50) begin
            tick();
            g++;
        end
        e.done = 1'b0;
    endtask

    task automatic session(input int flip, input int extra, input logic [7:0] sx, output bq_t kb);
        int ndiff = 0;
        int exp_err = (flip >= 0 && flip < ML) ? 1 : 0;
        kcnt = 0; pcnt = 0; ccnt = 0;
        // A message write in the same cycle as start must still land.
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 8'(ML - 1);
        cfg_data = msg_m[ML - 1] ^ sx;
        msg_m[ML - 1] = cfg_data;
        ct_m = model_ct();
        mon = 1'b1;
        tick();
        // Key write while busy must be dropped.
        start = 1'b0; cfg_sel = 1'b0; cfg_addr = 8'd5; cfg_data = ~key_m[5];
        chk("busy_key", 32'(busy), 1);
        engine(flip, extra, kb);
        chk("key_beats", 32'(kcnt), KL + 1);
        chk("plain_beats", 32'(pcnt), ML);
        chk("cipher_beats", 32'(ccnt), ML);
        chk("fin", 32'(fin), 1);
        chk("busy_fin", 32'(busy), 0);
        chk("err_count", 32'(err_count), 32'(exp_err));
        chk("pass", 32'(pass), 32'(exp_err == 0));
        for (int i = 0; i < ML; i++) begin
            rd_addr = 8'(i);
            #1;
            chk("rd_data", 32'(rd_data), 32'(ct_m[i]));
            if (rd_data != msg_m[8'(i)]) ndiff++;
        end
        chk("ct_differs", 32'(ndiff != 0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        bq_t kb, pin;
        int flip, n;
        e.plain_read = 1'b0; e.cipher_write = 1'b0; e.cipher_out = '0; e.cipher_read = 1'b0;
        e.plain_write = 1'b0; e.plain_out = '0; e.done = 1'b0;
        pin = '{8'h4B, 8'h65, 8'h79};
        pin = rc4(pin, 3);
        chk("model_ks0", 32'(pin[0]), 32'hEB);
        chk("model_ks1", 32'(pin[1]), 32'h9F);
        chk("model_ks2", 32'(pin[2]), 32'h77);
        #1;
        do_reset();
        for (int i = 0; i < KL; i++) load(1'b0, 8'(i), 8'(i + 1));
        for (int i = 0; i < ML; i++) load(1'b1, 8'(i), 8'(i));
        session(-1, 0, 8'h00, kb);
        chk("key_seq_len", 32'(kb.size()), KL + 1);
        chk("key_seq_0", 32'(kb.size() > 0 ? kb[0] : 8'h00), 32'h01);
        chk("key_seq_1", 32'(kb.size() > 1 ? kb[1] : 8'h00), 32'h01);
        chk("key_seq_2", 32'(kb.size() > 2 ? kb[2] : 8'h00), 32'h02);
        chk("key_seq_last", 32'(kb.size() > KL ? kb[KL] : 8'h00), 32'h20);
        do_reset();
        session(5, 0, 8'h00, kb);
        do_reset();
        session(-1, 3, 8'($urandom), kb);
        do_reset();
        kcnt = 0; pcnt = 0; ccnt = 0; mon = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        e.plain_read = 1'b1;
        repeat (KL + 4) tick();
        chk("busy_mid", 32'(busy), 1);
        chk("key_beats_mid", 32'(kcnt), KL + 1);
        chk("plain_beats_mid", 32'(pcnt), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_key_valid", 32'(e.key_valid), 0);
        chk("mid_rst_plain_valid", 32'(e.plain_in_valid), 0);
        e.plain_read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        session(-1, 0, 8'h00, kb);
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < KL; i++) load(1'b0, 8'(i), 8'($urandom));
            for (int i = 0; i < ML; i++) load(1'b1, 8'(i), 8'($urandom));
            flip = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, ML - 1)) : -1;
            session(flip, int'($urandom_range(0, 3)), 8'($urandom), kb);
        end
`ifdef RC4_HOST_TIMEOUT_EN
        do_reset();
        mon = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (e.key_valid && n < 100) begin
            tick();
            n++;
        end
        n = 0;
        while (!fin && n < 5000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 4096);
        chk("timeout_flag", 32'(timeout), 1);
        chk("timeout_pass", 32'(pass), 0);
`else
        n = 0;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rc4_host.md
RC4_HOST -- requirements
Module: rc4_host

Interface
REQ-001 SHALL have parameter KEY_LEN, 32, key bytes sent (1..32).
REQ-002 SHALL have parameter MSG_LEN, 16, message bytes per session (1..255).
REQ-003 SHALL have parameter TIMEOUT, 4096, watchdog idle-cycle limit.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  begin session.
- cfg_we  in  1  load strobe.
- cfg_sel  in  1  0 = key memory, 1 = message memory.
- cfg_addr  in  8  load address.
- cfg_data  in  8  load data.
- key_valid  out  1  key stream valid.
- key_in  out  8  key byte.
- plain_read  in  1  engine requests plaintext.
- plain_in_valid  out  1  plaintext byte valid.
- plain_in  out  8  plaintext byte.
- cipher_write  in  1  engine ciphertext strobe.
- cipher_out  in  8  ciphertext byte.
- cipher_read  in  1  engine requests ciphertext.
- cipher_in_valid  out  1  ciphertext byte valid.
- cipher_in  out  8  ciphertext byte.
- plain_write  in  1  engine recovered-plaintext strobe.
- plain_out  in  8  recovered byte.
- done  in  1  engine finished.
- rd_addr  in  8  ciphertext buffer readback address.
- rd_data  out  8  ciphertext buffer byte, combinational.
- busy  out  1  session active.
- fin  out  1  session complete.
- pass  out  1  fin with zero mismatches.
- err_count  out  8  mismatch count, saturating at 255.

Function
REQ-005 SHALL hold three 256x8 memories (key, message, ciphertext), not reset; cfg_we writes key/message at cfg_addr only in IDLE, ignored elsewhere.
REQ-006 SHALL have states IDLE, KEY, ENC, DEC, WAIT_DONE, FIN; busy=1 in KEY..WAIT_DONE.
REQ-007 IDLE->KEY on start=1; a simultaneous cfg_we write is still performed; start ignored outside IDLE.
REQ-008 KEY: key_valid=1 for exactly KEY_LEN+1 cycles (counter c=0..KEY_LEN); key_in=key[0] for c=0 and key[c-1] for c>=1; then key_valid=0 and state->ENC.
REQ-009 ENC: plain_in_valid = plain_read AND pidx<MSG_LEN, combinational; plain_in=msg[pidx]; pidx increments on each edge with plain_in_valid=1.
REQ-010 Capture SHALL require cipher_write=1 AND ppend=1, ppend being plain_in_valid registered one cycle; write cipher_out to cbuf[cidx], cidx++. Extra or held cipher_write cycles SHALL NOT capture.
REQ-011 ENC->DEC when cidx==MSG_LEN.
REQ-012 DEC: cipher_in_valid = cipher_read AND ridx<MSG_LEN; cipher_in=cbuf[ridx]; ridx++ per valid edge; recovered capture on plain_write AND cpend, cpend being cipher_in_valid registered; compare plain_out with msg[oidx], mismatch increments err_count (saturating), oidx++.
REQ-013 DEC->WAIT_DONE when oidx==MSG_LEN; WAIT_DONE->FIN on done=1.
REQ-014 FIN: fin=1, pass=(err_count==0); held until rst; start ignored.
REQ-015 plain_in_valid and cipher_in_valid SHALL be 0 outside ENC and DEC respectively.
REQ-016 rd_data = cbuf[rd_addr] in any state.

Reset
REQ-017 rst SHALL force IDLE, all counters 0, key_valid=0, key_in=0, busy=0, fin=0, pass=0, err_count=0, timeout=0, from any state including mid-session; memory contents retained.

Configuration
REQ-018 Macro RC4_HOST_TIMEOUT_EN: when defined, a watchdog counts cycles in ENC/DEC/WAIT_DONE without a capture or done; reaching TIMEOUT sets output timeout=1 and forces FIN with pass=0.
REQ-019 Without RC4_HOST_TIMEOUT_EN, no watchdog exists; port timeout is absent; the session may wait indefinitely.

Verification
REQ-020 Key 0x01..0x20, msg 0x00..0x0F, real engine attached, start -> fin=1, pass=1, err_count=0, rd_data(0..15) differs from msg for at least one byte.
REQ-021 Start, KEY_LEN=32 -> key_valid high exactly 33 cycles; key_in sequence 0x01,0x01,0x02,...,0x20.
REQ-022 Bench engine model flips bit 0 of recovered byte 5 -> err_count=1, pass=0 at fin.
REQ-023 Engine model holds cipher_write high 3 cycles after the last byte -> exactly 16 bytes captured; ENC->DEC once; no ciphertext overwrite.
REQ-024 rst asserted mid-ENC -> next cycle IDLE, busy=0, key_valid=0; key/message memories unchanged; a new start reruns the session to pass=1.
REQ-025 With RC4_HOST_TIMEOUT_EN, engine never asserts plain_read -> timeout=1 and fin=1 exactly 4096 cycles after ENC entry, pass=0.
